// File: rtl/mem_port_arbiter_pkg.sv
// Types shared by the memory-port arbiter, its bus interface and the cache-side users.
package mem_if_pkg;
    localparam int ADDR_W_DEF = 32;
    localparam int LINE_W_DEF = 128;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    typedef enum logic {OP_RD, OP_WR} op_t;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// Client-side request/response bus plus the single line-wide memory port.
interface mem_port_arbiter_if #(
    parameter int NUM_CLIENTS = 2,
    parameter int ADDR_W      = mem_if_pkg::ADDR_W_DEF,
    parameter int LINE_W      = mem_if_pkg::LINE_W_DEF
);
    logic [NUM_CLIENTS-1:0]        cl_rd;
    logic [NUM_CLIENTS-1:0]        cl_wr;
    logic [NUM_CLIENTS*ADDR_W-1:0] cl_addr;
    logic [NUM_CLIENTS*LINE_W-1:0] cl_wdata;
    logic [NUM_CLIENTS-1:0]        cl_busy;
    logic [NUM_CLIENTS-1:0]        cl_done;
    logic [LINE_W-1:0]             cl_rdata;
    logic                          proto_err;
    logic                          mem_rd;
    logic                          mem_wr;
    logic [ADDR_W-1:0]             mem_addr;
    logic [LINE_W-1:0]             mem_wdata;
    logic [LINE_W-1:0]             mem_rdata;
    logic                          mem_ready;

    modport master (
        input  cl_rd, cl_wr, cl_addr, cl_wdata, mem_rdata, mem_ready,
        output cl_busy, cl_done, cl_rdata, proto_err, mem_rd, mem_wr, mem_addr, mem_wdata
    );

    modport slave (
        output cl_rd, cl_wr, cl_addr, cl_wdata, mem_rdata, mem_ready,
        input  cl_busy, cl_done, cl_rdata, proto_err, mem_rd, mem_wr, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter_rr_pick.sv
// Combinational winner select: lowest index, or first eligible after ptr when rr_mode.
module rr_pick #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     eligible,
    input  logic [IDX_W-1:0] ptr,
    input  logic             rr_mode,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);
    always_comb begin
        int c;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        c     = 0;
        for (int k = 0; k < N; k++) begin
            c = rr_mode ? (int'(ptr) + 1 + k) % N : k;
            if (!any && eligible[c]) begin
                any      = 1'b1;
                grant[c] = 1'b1;
                idx      = IDX_W'(c);
            end
        end
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port among NUM_CLIENTS caches; one transaction in flight at a time.
module mem_port_arbiter
    import mem_if_pkg::*;
#(
    parameter int NUM_CLIENTS = 2,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int LINE_W      = LINE_W_DEF,
    parameter int RR_MODE     = 0
) (
    input logic                clk,
    input logic                rst_n,
    mem_port_arbiter_if.master bus
);
    localparam int IDX_W = $clog2(NUM_CLIENTS);

    typedef struct packed {
        op_t               op;
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] wdata;
    } req_t;

    state_t                 state;
    req_t                   req;
    logic [IDX_W-1:0]       gnt_idx, ptr, pick_idx;
    logic [NUM_CLIENTS-1:0] cooldown, eligible, pick_grant, busy, done;
    logic [LINE_W-1:0]      rdata;
    logic                   pick_any, perr, mrd, mwr;
    logic [ADDR_W-1:0]      addr_arr  [NUM_CLIENTS];
    logic [LINE_W-1:0]      wdata_arr [NUM_CLIENTS];

    for (genvar i = 0; i < NUM_CLIENTS; i++) begin : g_unpack
        assign addr_arr[i]  = bus.cl_addr[i*ADDR_W +: ADDR_W];
        assign wdata_arr[i] = bus.cl_wdata[i*LINE_W +: LINE_W];
    end

    // Cooldown hides a just-served client whose level request has not yet dropped.
    assign eligible = (bus.cl_rd | bus.cl_wr) & ~cooldown;

    rr_pick #(.N(NUM_CLIENTS), .IDX_W(IDX_W)) u_pick (
        .eligible (eligible),
        .ptr      (ptr),
        .rr_mode  (RR_MODE != 0),
        .grant    (pick_grant),
        .idx      (pick_idx),
        .any      (pick_any)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            req      <= '0;
            gnt_idx  <= '0;
            ptr      <= IDX_W'(NUM_CLIENTS - 1);
            cooldown <= '0;
            busy     <= '0;
            done     <= '0;
            rdata    <= '0;
            perr     <= 1'b0;
            mrd      <= 1'b0;
            mwr      <= 1'b0;
        end else begin
            done     <= '0;
            cooldown <= '0;
            if (|(bus.cl_rd & bus.cl_wr)) perr <= 1'b1;
            case (state)
                IDLE: if (pick_any) begin
                    gnt_idx   <= pick_idx;
                    req.op    <= bus.cl_wr[pick_idx] ? OP_WR : OP_RD;
                    req.addr  <= addr_arr[pick_idx];
                    req.wdata <= wdata_arr[pick_idx];
                    busy      <= pick_grant;
                    state     <= ISSUE;
                end
                ISSUE: begin
                    mrd   <= (req.op == OP_RD);
                    mwr   <= (req.op == OP_WR);
                    state <= WAIT;
                end
                WAIT: if (bus.mem_ready) begin
                    mrd           <= 1'b0;
                    mwr           <= 1'b0;
                    if (req.op == OP_RD) rdata <= bus.mem_rdata;
                    done[gnt_idx] <= 1'b1;
                    busy          <= '0;
                    state         <= DONE;
                end
                DONE: begin
                    if (RR_MODE != 0) ptr <= gnt_idx;
                    cooldown[gnt_idx] <= 1'b1;
                    state             <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.cl_busy   = busy;
    assign bus.cl_done   = done;
    assign bus.cl_rdata  = rdata;
    assign bus.proto_err = perr;
    assign bus.mem_rd    = mrd;
    assign bus.mem_wr    = mwr;
    assign bus.mem_addr  = req.addr;
    assign bus.mem_wdata = req.wdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: a fixed-priority and a round-robin instance, one exercised at a time via sel.
module tb_mem_port_arbiter;
    localparam int NC = 2;
    localparam int AW = 32;
    localparam int LW = 128;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic          sel = 1'b0;
    logic [NC-1:0] rd = '0, wr = '0;
    logic [AW-1:0] a0 = '0, a1 = '0;
    logic [LW-1:0] wd0 = '0, wd1 = '0, m_rdata = '0;
    logic          m_ready = 1'b0;

    mem_port_arbiter_if #(.NUM_CLIENTS(NC), .ADDR_W(AW), .LINE_W(LW)) if_fix ();
    mem_port_arbiter_if #(.NUM_CLIENTS(NC), .ADDR_W(AW), .LINE_W(LW)) if_rr ();

    assign if_fix.cl_rd     = sel ? '0 : rd;
    assign if_fix.cl_wr     = sel ? '0 : wr;
    assign if_fix.cl_addr   = {a1, a0};
    assign if_fix.cl_wdata  = {wd1, wd0};
    assign if_fix.mem_rdata = m_rdata;
    assign if_fix.mem_ready = m_ready;
    assign if_rr.cl_rd      = sel ? rd : '0;
    assign if_rr.cl_wr      = sel ? wr : '0;
    assign if_rr.cl_addr    = {a1, a0};
    assign if_rr.cl_wdata   = {wd1, wd0};
    assign if_rr.mem_rdata  = m_rdata;
    assign if_rr.mem_ready  = m_ready;

    mem_port_arbiter #(.NUM_CLIENTS(NC), .ADDR_W(AW), .LINE_W(LW), .RR_MODE(0)) u_fix (
        .clk(clk), .rst_n(rst_n), .bus(if_fix));
    mem_port_arbiter #(.NUM_CLIENTS(NC), .ADDR_W(AW), .LINE_W(LW), .RR_MODE(1)) u_rr (
        .clk(clk), .rst_n(rst_n), .bus(if_rr));

    logic [NC-1:0] busy, done;
    logic [LW-1:0] rdata, mwdata;
    logic [AW-1:0] maddr;
    logic          perr, mrd, mwr;
    assign busy   = sel ? if_rr.cl_busy   : if_fix.cl_busy;
    assign done   = sel ? if_rr.cl_done   : if_fix.cl_done;
    assign rdata  = sel ? if_rr.cl_rdata  : if_fix.cl_rdata;
    assign perr   = sel ? if_rr.proto_err : if_fix.proto_err;
    assign mrd    = sel ? if_rr.mem_rd    : if_fix.mem_rd;
    assign mwr    = sel ? if_rr.mem_wr    : if_fix.mem_wr;
    assign maddr  = sel ? if_rr.mem_addr  : if_fix.mem_addr;
    assign mwdata = sel ? if_rr.mem_wdata : if_fix.mem_wdata;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory responder: waits for a strobe, answers lat cycles in (1 = first WAIT cycle),
    // reports the strobe snapshot, whether it held steady, and which client got done.
    task automatic serve(input logic [LW-1:0] rdv, input int lat, output int who,
                         output logic s_rd, output logic s_wr, output logic [AW-1:0] s_addr,
                         output logic [LW-1:0] s_wd, output logic hold);
        int n = 0;
        who  = -1;
        hold = 1'b0;
        while (!(mrd | mwr) && n < 20) begin
            tick();
            n++;
        end
        s_rd = mrd; s_wr = mwr; s_addr = maddr; s_wd = mwdata;
        if (!(mrd | mwr)) begin
            chk("strobe_timeout", 1'b0, 1'b1);
            return;
        end
        hold = 1'b1;
        for (int i = 1; i < lat; i++) begin
            tick();
            if (!(mrd == s_rd && mwr == s_wr && maddr == s_addr && mwdata == s_wd && done == '0))
                hold = 1'b0;
        end
        m_ready = 1'b1;
        m_rdata = rdv;
        tick();
        m_ready = 1'b0;
        m_rdata = '0;
        if (done == 2'b01) who = 0;
        else if (done == 2'b10) who = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    localparam logic [LW-1:0] R1 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    localparam logic [LW-1:0] R3 = 128'h0F0F_0F0F_A5A5_A5A5_1234_5678_9ABC_DEF0;
    localparam logic [LW-1:0] R6 = 128'hCAFE_F00D_0000_1111_2222_3333_4444_5555;
    localparam logic [LW-1:0] WD = 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF;

    initial begin
        int who, r0;
        logic srd, swr, hold;
        logic [AW-1:0] sad;
        logic [LW-1:0] swd;

        // reset state
        repeat (2) tick();
        chk("rst_busy", busy, '0);
        chk("rst_done", done, '0);
        chk("rst_rdata", rdata, '0);
        chk("rst_perr", perr, '0);
        chk("rst_mrd", mrd, '0);
        chk("rst_mwr", mwr, '0);
        chk("rst_maddr", maddr, '0);
        rst_n = 1'b1;
        tick();

        // single read, client 1, ready arriving 3 cycles after the strobe
        a1 = 32'h40; rd = 2'b10; r0 = cyc;
        tick();
        chk("t1_busy_grant", busy, 2'b10);
        chk("t1_no_strobe_issue", mrd, 1'b0);
        serve(R1, 4, who, srd, swr, sad, swd, hold);
        chk("t1_who", 128'(who), 128'(1));
        chk("t1_addr", sad, 32'h40);
        chk("t1_rd_strobe", {srd, swr}, 2'b10);
        chk("t1_hold", hold, 1'b1);
        chk("t1_latency", 128'(cyc - r0), 128'(6));
        chk("t1_rdata", rdata, R1);
        chk("t1_strobe_drop", {mrd, mwr}, 2'b00);
        chk("t1_busy_clr", busy, '0);
        tick();
        rd = '0;
        chk("t1_done_1cyc", done, '0);
        tick();

        // stray mem_ready while idle
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        chk("idle_ready_done", done, '0);
        chk("idle_ready_busy", busy, '0);
        tick();

        // simultaneous reads, fixed priority, minimum latency
        a0 = 32'h100; a1 = 32'h200; rd = 2'b11; r0 = cyc;
        serve(R3, 1, who, srd, swr, sad, swd, hold);
        chk("t2f_first", 128'(who), 128'(0));
        chk("t2f_first_addr", sad, 32'h100);
        chk("t2f_min_lat", 128'(cyc - r0), 128'(3));
        rd[0] = 1'b0;
        serve(R3, 2, who, srd, swr, sad, swd, hold);
        chk("t2f_second", 128'(who), 128'(1));
        chk("t2f_second_addr", sad, 32'h200);
        rd[1] = 1'b0;
        repeat (2) tick();

        // client 0 holds one extra cycle after done; cooldown must hand over to client 1
        rd = 2'b11;
        serve(R3, 1, who, srd, swr, sad, swd, hold);
        chk("t3_first", 128'(who), 128'(0));
        tick();
        tick();
        chk("t3_busy_c1", busy, 2'b10);
        rd[0] = 1'b0;
        serve(R3, 2, who, srd, swr, sad, swd, hold);
        chk("t3_second", 128'(who), 128'(1));
        rd[1] = 1'b0;
        repeat (3) tick();
        chk("t3_no_dup_busy", busy, '0);
        chk("t3_no_dup_strobe", {mrd, mwr}, 2'b00);

        // write from client 0
        a0 = 32'h80; wd0 = WD; wr = 2'b01;
        serve(128'h5555_5555_5555_5555_5555_5555_5555_5555, 3, who, srd, swr, sad, swd, hold);
        chk("t4_who", 128'(who), 128'(0));
        chk("t4_wr_strobe", {srd, swr}, 2'b01);
        chk("t4_wdata", swd, WD);
        chk("t4_hold", hold, 1'b1);
        chk("t4_rdata_kept", rdata, R3);
        chk("t4_perr", perr, 1'b0);
        wr = '0;
        tick();

        // rd and wr together from client 1
        a1 = 32'hC0; wd1 = ~WD; rd = 2'b10; wr = 2'b10;
        serve(R1, 2, who, srd, swr, sad, swd, hold);
        chk("t5_who", 128'(who), 128'(1));
        chk("t5_as_write", {srd, swr}, 2'b01);
        chk("t5_wdata", swd, ~WD);
        chk("t5_perr", perr, 1'b1);
        rd = '0; wr = '0;
        repeat (3) tick();
        chk("t5_perr_sticky", perr, 1'b1);

        // round-robin instance, untouched since reset
        sel = 1'b1;
        tick();
        for (int r = 0; r < 2; r++) begin
            rd = 2'b11;
            serve(R1, 1, who, srd, swr, sad, swd, hold);
            chk("t2r_pair_first", 128'(who), 128'(0));
            rd[0] = 1'b0;
            serve(R1, 1, who, srd, swr, sad, swd, hold);
            chk("t2r_pair_second", 128'(who), 128'(1));
            rd[1] = 1'b0;
            tick();
        end
        rd = 2'b01;
        serve(R1, 1, who, srd, swr, sad, swd, hold);
        chk("t2r_solo0", 128'(who), 128'(0));
        rd = '0;
        repeat (2) tick();
        rd = 2'b11;
        serve(R1, 1, who, srd, swr, sad, swd, hold);
        chk("t2r_after_ptr0", 128'(who), 128'(1));
        rd[1] = 1'b0;
        serve(R1, 1, who, srd, swr, sad, swd, hold);
        chk("t2r_then0", 128'(who), 128'(0));
        rd = '0;
        tick();
        sel = 1'b0;
        tick();

        // reset during WAIT
        a0 = 32'h240; rd = 2'b01;
        for (int n = 0; n < 10 && !mrd; n++) tick();
        chk("t6_in_wait", mrd, 1'b1);
        tick();
        rst_n = 1'b0;
        tick();
        chk("t6_mrd_drop", mrd, 1'b0);
        chk("t6_busy_clr", busy, '0);
        chk("t6_no_done", done, '0);
        chk("t6_perr_clr", perr, 1'b0);
        rd = '0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("t6_no_done_after", done, '0);
        a0 = 32'h300; rd = 2'b01;
        serve(R6, 2, who, srd, swr, sad, swd, hold);
        chk("t6_fresh_who", 128'(who), 128'(0));
        chk("t6_fresh_addr", sad, 32'h300);
        chk("t6_fresh_rdata", rdata, R6);
        rd = '0;
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
